// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpu_pkg
// Purpose  : Shared types and default sizing for the MPU matrix register file.
// Revision : 1.0  initial release
// ============================================================================
package mpu_pkg;

    localparam int c_FP_DEF    = 16;
    localparam int c_M_DEF     = 4;
    localparam int c_N_DEF     = 4;
    localparam int c_MBITS_DEF = 2;
    localparam int c_NBITS_DEF = 2;
    localparam int c_MRS_DEF   = 2;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic                   valid;
        logic [c_MBITS_DEF:0]   m;
        logic [c_NBITS_DEF:0]   n;
    } slot_desc_t;

endpackage
`default_nettype wire

// File: rtl/mpu_rf_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mpu_rf_read_ctrl
// Purpose  : Read FSM streaming one stored matrix row-major with ready/valid.
// Revision : 1.0  initial release
// ============================================================================
module mpu_rf_read_ctrl
    import mpu_pkg::*;
#(
    parameter int FP              = c_FP_DEF,
    parameter int MBITS           = c_MBITS_DEF,
    parameter int NBITS           = c_NBITS_DEF,
    parameter int MATRIX_REG_SIZE = c_MRS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req_in,
    input  logic [MATRIX_REG_SIZE-1:0] rd_addr_in,
    input  logic                       rd_ready_in,
    input  logic                       sel_valid_in,
    input  logic [MBITS:0]             sel_m_in,
    input  logic [NBITS:0]             sel_n_in,
    input  logic                       abort_in,
    output logic [MATRIX_REG_SIZE-1:0] fetch_addr_out,
    output logic [MBITS:0]             fetch_i_out,
    output logic [NBITS:0]             fetch_j_out,
    input  logic [FP-1:0]              fetch_data_in,
    output logic [MATRIX_REG_SIZE-1:0] stream_addr_out,
    output logic                       rd_valid_out,
    output logic [FP-1:0]              rd_element_out,
    output logic [MBITS:0]             rd_i_out,
    output logic [NBITS:0]             rd_j_out,
    output logic [MBITS:0]             rd_m_size_out,
    output logic [NBITS:0]             rd_n_size_out,
    output logic                       rd_last_out,
    output logic                       rd_busy_out,
    output logic                       err_out
);

    localparam logic [MBITS:0] c_I1 = {{MBITS{1'b0}}, 1'b1};
    localparam logic [NBITS:0] c_J1 = {{NBITS{1'b0}}, 1'b1};

    rd_state_t                  state_q, state_d;
    logic [MATRIX_REG_SIZE-1:0] addr_q, addr_d;
    logic [MBITS:0]             i_q, i_d, m_q, m_d, w_ni;
    logic [NBITS:0]             j_q, j_d, n_q, n_d, w_nj;
    logic                       valid_q, valid_d, last_q, last_d;
    logic [FP-1:0]              elem_q, elem_d;

    // Next row-major position and the storage location to prefetch into the output register.
    always_comb begin
        w_ni = i_q;
        w_nj = j_q + c_J1;
        if (j_q == n_q - c_J1) begin
            w_nj = '0;
            w_ni = i_q + c_I1;
        end
        if (state_q == RD_IDLE) begin
            fetch_addr_out = rd_addr_in;
            fetch_i_out    = '0;
            fetch_j_out    = '0;
        end else begin
            fetch_addr_out = addr_q;
            fetch_i_out    = w_ni;
            fetch_j_out    = w_nj;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        i_d     = i_q;
        j_d     = j_q;
        m_d     = m_q;
        n_d     = n_q;
        valid_d = valid_q;
        last_d  = last_q;
        elem_d  = elem_q;
        err_out = 1'b0;
        case (state_q)
            RD_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (rd_req_in) begin
                    if (sel_valid_in) begin
                        state_d = RD_STREAM;
                        addr_d  = rd_addr_in;
                        i_d     = '0;
                        j_d     = '0;
                        m_d     = sel_m_in;
                        n_d     = sel_n_in;
                        elem_d  = fetch_data_in;
                        valid_d = 1'b1;
                        last_d  = (sel_m_in == c_I1) && (sel_n_in == c_J1);
                    end else begin
                        err_out = 1'b1;
                    end
                end
            end
            RD_STREAM: begin
                if (abort_in) begin
                    state_d = RD_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    err_out = 1'b1;
                end else if (valid_q && rd_ready_in) begin
                    if (last_q) begin
                        state_d = RD_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        i_d    = w_ni;
                        j_d    = w_nj;
                        elem_d = fetch_data_in;
                        last_d = (w_ni == m_q - c_I1) && (w_nj == n_q - c_J1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            i_q     <= i_d;
            j_q     <= j_d;
            m_q     <= m_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            elem_q  <= elem_d;
        end
    end

    assign stream_addr_out = addr_q;
    assign rd_valid_out    = valid_q;
    assign rd_element_out  = elem_q;
    assign rd_i_out        = i_q;
    assign rd_j_out        = j_q;
    assign rd_m_size_out   = m_q;
    assign rd_n_size_out   = n_q;
    assign rd_last_out     = last_q;
    assign rd_busy_out     = (state_q == RD_STREAM);

endmodule
`default_nettype wire

// File: rtl/mpu_matrix_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mpu_matrix_regfile
// Purpose  : Matrix register file: element-wise load port, streaming read port.
//            Optional MPU_RF_CLEAR_EN adds a single-cycle slot clear port.
// Revision : 1.0  initial release
// ============================================================================
module mpu_matrix_regfile
    import mpu_pkg::*;
#(
    parameter int FP              = c_FP_DEF,
    parameter int M               = c_M_DEF,
    parameter int N               = c_N_DEF,
    parameter int MBITS           = c_MBITS_DEF,
    parameter int NBITS           = c_NBITS_DEF,
    parameter int MATRIX_REG_SIZE = c_MRS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reg_load_en_in,
    input  logic [MATRIX_REG_SIZE-1:0]    reg_load_addr_in,
    input  logic [FP-1:0]                 reg_load_element_in,
    input  logic [MBITS:0]                reg_i_load_loc_in,
    input  logic [NBITS:0]                reg_j_load_loc_in,
    input  logic [MBITS:0]                reg_m_load_size_in,
    input  logic [NBITS:0]                reg_n_load_size_in,
`ifdef MPU_RF_CLEAR_EN
    input  logic                          clear_en_in,
    input  logic [MATRIX_REG_SIZE-1:0]    clear_addr_in,
`endif
    input  logic                          rd_req_in,
    input  logic [MATRIX_REG_SIZE-1:0]    rd_addr_in,
    input  logic                          rd_ready_in,
    output logic                          rd_valid_out,
    output logic [FP-1:0]                 rd_element_out,
    output logic [MBITS:0]                rd_i_out,
    output logic [NBITS:0]                rd_j_out,
    output logic [MBITS:0]                rd_m_size_out,
    output logic [NBITS:0]                rd_n_size_out,
    output logic                          rd_last_out,
    output logic                          rd_busy_out,
    output logic                          err_out,
    output logic [2**MATRIX_REG_SIZE-1:0] slot_valid_out
);

    localparam int             SLOTS   = 2**MATRIX_REG_SIZE;
    localparam int             c_DEPTH = SLOTS * M * N;
    localparam int             c_AW    = $clog2(c_DEPTH);
    localparam logic [MBITS:0] c_M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] c_N_MAX = (NBITS+1)'(N);
    localparam logic [MBITS:0] c_I1    = {{MBITS{1'b0}}, 1'b1};
    localparam logic [NBITS:0] c_J1    = {{NBITS{1'b0}}, 1'b1};

    logic [FP-1:0]              mem [c_DEPTH];
    slot_desc_t                 slot_q [SLOTS];
    slot_desc_t                 slot_d [SLOTS];
    logic                       err_q;
    logic                       w_clr_en, w_wr_ok, w_wr_bad, w_first, w_final, w_abort;
    logic                       w_rd_err, w_busy;
    logic [MATRIX_REG_SIZE-1:0] w_clr_addr, w_fetch_addr, w_stream_addr;
    logic [MBITS:0]             w_fetch_i;
    logic [NBITS:0]             w_fetch_j;
    logic [FP-1:0]              w_fetch_data;
    logic [c_AW-1:0]            w_wr_idx, w_rd_idx;

`ifdef MPU_RF_CLEAR_EN
    assign w_clr_en   = clear_en_in;
    assign w_clr_addr = clear_addr_in;
`else
    assign w_clr_en   = 1'b0;
    assign w_clr_addr = '0;
`endif

    assign w_wr_ok  = reg_load_en_in
                   && (reg_m_load_size_in != '0) && (reg_m_load_size_in <= c_M_MAX)
                   && (reg_n_load_size_in != '0) && (reg_n_load_size_in <= c_N_MAX)
                   && (reg_i_load_loc_in < reg_m_load_size_in)
                   && (reg_j_load_loc_in < reg_n_load_size_in);
    assign w_wr_bad = reg_load_en_in && !w_wr_ok;
    assign w_first  = (reg_i_load_loc_in == '0) && (reg_j_load_loc_in == '0);
    assign w_final  = (reg_i_load_loc_in == reg_m_load_size_in - c_I1)
                   && (reg_j_load_loc_in == reg_n_load_size_in - c_J1);
    assign w_abort  = (w_wr_ok && (reg_load_addr_in == w_stream_addr))
                   || (w_clr_en && (w_clr_addr == w_stream_addr));

    assign w_wr_idx = c_AW'(int'(reg_load_addr_in) * M * N
                          + int'(reg_i_load_loc_in) * N + int'(reg_j_load_loc_in));
    assign w_rd_idx = c_AW'(int'(w_fetch_addr) * M * N
                          + int'(w_fetch_i) * N + int'(w_fetch_j));
    assign w_fetch_data = mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem[w_wr_idx] <= reg_load_element_in;
        end
    end

    // Clear is applied last so it overrides a concurrent final write to the same slot.
    always_comb begin
        slot_d = slot_q;
        if (w_wr_ok) begin
            if (w_first) begin
                slot_d[reg_load_addr_in].m     = reg_m_load_size_in;
                slot_d[reg_load_addr_in].n     = reg_n_load_size_in;
                slot_d[reg_load_addr_in].valid = 1'b0;
            end
            if (w_final) begin
                slot_d[reg_load_addr_in].valid = 1'b1;
            end
            if (w_busy && (reg_load_addr_in == w_stream_addr)) begin
                slot_d[reg_load_addr_in].valid = 1'b0;
            end
        end
        if (w_clr_en) begin
            slot_d[w_clr_addr] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SLOTS; k++) begin
                slot_q[k] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            err_q  <= w_wr_bad | w_rd_err;
        end
    end

    mpu_rf_read_ctrl #(
        .FP              (FP),
        .MBITS           (MBITS),
        .NBITS           (NBITS),
        .MATRIX_REG_SIZE (MATRIX_REG_SIZE)
    ) u_read_ctrl (
        .clk             (clk),
        .rst             (rst),
        .rd_req_in       (rd_req_in),
        .rd_addr_in      (rd_addr_in),
        .rd_ready_in     (rd_ready_in),
        .sel_valid_in    (slot_q[rd_addr_in].valid),
        .sel_m_in        (slot_q[rd_addr_in].m),
        .sel_n_in        (slot_q[rd_addr_in].n),
        .abort_in        (w_abort),
        .fetch_addr_out  (w_fetch_addr),
        .fetch_i_out     (w_fetch_i),
        .fetch_j_out     (w_fetch_j),
        .fetch_data_in   (w_fetch_data),
        .stream_addr_out (w_stream_addr),
        .rd_valid_out    (rd_valid_out),
        .rd_element_out  (rd_element_out),
        .rd_i_out        (rd_i_out),
        .rd_j_out        (rd_j_out),
        .rd_m_size_out   (rd_m_size_out),
        .rd_n_size_out   (rd_n_size_out),
        .rd_last_out     (rd_last_out),
        .rd_busy_out     (w_busy),
        .err_out         (w_rd_err)
    );

    assign rd_busy_out = w_busy;
    assign err_out     = err_q;

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot_valid
        assign slot_valid_out[k] = slot_q[k].valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_mpu_matrix_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpu_matrix_regfile
// Purpose  : Directed self-checking bench for mpu_matrix_regfile.
// Revision : 1.0  initial release
// ============================================================================
module tb_mpu_matrix_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_load_en_in = 1'b0;
    logic [1:0]  reg_load_addr_in = '0;
    logic [15:0] reg_load_element_in = '0;
    logic [2:0]  reg_i_load_loc_in = '0;
    logic [2:0]  reg_j_load_loc_in = '0;
    logic [2:0]  reg_m_load_size_in = '0;
    logic [2:0]  reg_n_load_size_in = '0;
    logic        rd_req_in = 1'b0;
    logic [1:0]  rd_addr_in = '0;
    logic        rd_ready_in = 1'b0;
    logic        rd_valid_out;
    logic [15:0] rd_element_out;
    logic [2:0]  rd_i_out, rd_j_out, rd_m_size_out, rd_n_size_out;
    logic        rd_last_out, rd_busy_out, err_out;
    logic [3:0]  slot_valid_out;

    int checks = 0;
    int passed = 0;

    logic [15:0] e23 [6] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};

    mpu_matrix_regfile dut (
        .clk                 (clk),
        .rst                 (rst),
        .reg_load_en_in      (reg_load_en_in),
        .reg_load_addr_in    (reg_load_addr_in),
        .reg_load_element_in (reg_load_element_in),
        .reg_i_load_loc_in   (reg_i_load_loc_in),
        .reg_j_load_loc_in   (reg_j_load_loc_in),
        .reg_m_load_size_in  (reg_m_load_size_in),
        .reg_n_load_size_in  (reg_n_load_size_in),
        .rd_req_in           (rd_req_in),
        .rd_addr_in          (rd_addr_in),
        .rd_ready_in         (rd_ready_in),
        .rd_valid_out        (rd_valid_out),
        .rd_element_out      (rd_element_out),
        .rd_i_out            (rd_i_out),
        .rd_j_out            (rd_j_out),
        .rd_m_size_out       (rd_m_size_out),
        .rd_n_size_out       (rd_n_size_out),
        .rd_last_out         (rd_last_out),
        .rd_busy_out         (rd_busy_out),
        .err_out             (err_out),
        .slot_valid_out      (slot_valid_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input int i, input int j,
                      input int m, input int n, input logic [15:0] d);
        reg_load_en_in      = 1'b1;
        reg_load_addr_in    = a;
        reg_i_load_loc_in   = 3'(i);
        reg_j_load_loc_in   = 3'(j);
        reg_m_load_size_in  = 3'(m);
        reg_n_load_size_in  = 3'(n);
        reg_load_element_in = d;
        tick();
        reg_load_en_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({rd_valid_out, rd_last_out, rd_busy_out, err_out} !== 4'b0) $display("FAIL reset_ctrl got %b exp 0000", {rd_valid_out, rd_last_out, rd_busy_out, err_out});
        else passed++;
        checks++;
        if (slot_valid_out !== 4'b0) $display("FAIL reset_slot_valid got %b exp 0000", slot_valid_out);
        else passed++;
        checks++;
        if ({rd_i_out, rd_j_out, rd_m_size_out, rd_n_size_out} !== 12'h0) $display("FAIL reset_idx got %h exp 000", {rd_i_out, rd_j_out, rd_m_size_out, rd_n_size_out});
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_invalid();
        rd_req_in = 1'b1; rd_addr_in = 2'd0;
        tick();
        rd_req_in = 1'b0;
        checks++;
        if ({err_out, rd_valid_out, rd_busy_out} !== 3'b100) $display("FAIL rd_invalid_err got %b exp 100", {err_out, rd_valid_out, rd_busy_out});
        else passed++;
        tick();
        checks++;
        if ({err_out, rd_valid_out} !== 2'b00) $display("FAIL rd_invalid_pulse got %b exp 00", {err_out, rd_valid_out});
        else passed++;
    endtask

    task automatic test_stream_basic();
        for (int k = 0; k < 6; k++) wr(2'd1, k / 3, k % 3, 2, 3, e23[k]);
        checks++;
        if (slot_valid_out !== 4'b0010) $display("FAIL basic_slot_valid got %b exp 0010", slot_valid_out);
        else passed++;
        rd_ready_in = 1'b1;
        rd_req_in = 1'b1; rd_addr_in = 2'd1;
        tick();
        rd_req_in = 1'b0;
        for (int b = 0; b < 6; b++) begin
            checks++;
            if ({rd_valid_out, rd_busy_out, rd_element_out, rd_i_out, rd_j_out, rd_last_out, rd_m_size_out, rd_n_size_out}
                !== {2'b11, e23[b], 3'(b / 3), 3'(b % 3), (b == 5), 3'd2, 3'd3})
                $display("FAIL basic_beat%0d got v=%b e=%h i=%0d j=%0d last=%b m=%0d n=%0d exp e=%h i=%0d j=%0d",
                         b, rd_valid_out, rd_element_out, rd_i_out, rd_j_out, rd_last_out, rd_m_size_out, rd_n_size_out,
                         e23[b], b / 3, b % 3);
            else passed++;
            tick();
        end
        checks++;
        if ({rd_valid_out, rd_busy_out, err_out} !== 3'b000) $display("FAIL basic_end got %b exp 000", {rd_valid_out, rd_busy_out, err_out});
        else passed++;
        rd_ready_in = 1'b0;
    endtask

    task automatic test_same_cycle_req();
        rd_req_in = 1'b1; rd_addr_in = 2'd3;
        wr(2'd3, 0, 0, 1, 1, 16'h7777);
        rd_req_in = 1'b0;
        checks++;
        if ({err_out, rd_valid_out, rd_busy_out, slot_valid_out[3]} !== 4'b1001) $display("FAIL same_cycle_req got %b exp 1001", {err_out, rd_valid_out, rd_busy_out, slot_valid_out[3]});
        else passed++;
        rd_ready_in = 1'b1;
        rd_req_in = 1'b1;
        tick();
        rd_req_in = 1'b0;
        checks++;
        if ({rd_valid_out, rd_last_out, rd_element_out} !== {2'b11, 16'h7777}) $display("FAIL one_by_one got v=%b l=%b e=%h exp v=1 l=1 e=7777", rd_valid_out, rd_last_out, rd_element_out);
        else passed++;
        tick();
        checks++;
        if ({rd_valid_out, rd_busy_out} !== 2'b00) $display("FAIL one_by_one_end got %b exp 00", {rd_valid_out, rd_busy_out});
        else passed++;
        rd_ready_in = 1'b0;
    endtask

    task automatic test_backpressure();
        int k = 0;
        int hs = 0;
        int cyc = 0;
        int bad = 0;
        for (int e = 0; e < 16; e++) wr(2'd0, e / 4, e % 4, 4, 4, 16'h0100 + 16'(e));
        rd_req_in = 1'b1; rd_addr_in = 2'd0;
        tick();
        rd_req_in = 1'b0;
        while (k < 16 && cyc < 100) begin
            rd_ready_in = (cyc % 2 == 0);
            if ({rd_valid_out, rd_element_out, rd_i_out, rd_j_out, rd_last_out}
                !== {1'b1, 16'h0100 + 16'(k), 3'(k / 4), 3'(k % 4), (k == 15)}) begin
                if (bad == 0) $display("FAIL bp_beat%0d got v=%b e=%h i=%0d j=%0d l=%b exp e=%h", k, rd_valid_out, rd_element_out, rd_i_out, rd_j_out, rd_last_out, 16'h0100 + 16'(k));
                bad++;
            end
            tick();
            if (rd_ready_in) begin
                k++;
                hs++;
            end
            cyc++;
        end
        rd_ready_in = 1'b0;
        checks++;
        if (bad !== 0) $display("FAIL bp_elements got %0d bad beats exp 0", bad);
        else passed++;
        checks++;
        if (hs !== 16 || cyc !== 31) $display("FAIL bp_handshakes got %0d in %0d cycles exp 16 in 31", hs, cyc);
        else passed++;
        checks++;
        if ({rd_valid_out, rd_busy_out} !== 2'b00) $display("FAIL bp_end got %b exp 00", {rd_valid_out, rd_busy_out});
        else passed++;
    endtask

    task automatic test_bad_write();
        wr(2'd1, 3, 0, 2, 3, 16'hFFFF);
        checks++;
        if ({err_out, slot_valid_out[1]} !== 2'b11) $display("FAIL bad_write_err got %b exp 11", {err_out, slot_valid_out[1]});
        else passed++;
        rd_ready_in = 1'b1;
        rd_req_in = 1'b1; rd_addr_in = 2'd1;
        tick();
        rd_req_in = 1'b0;
        for (int b = 0; b < 6; b++) begin
            checks++;
            if ({rd_valid_out, rd_element_out} !== {1'b1, e23[b]}) $display("FAIL bad_write_reread%0d got v=%b e=%h exp e=%h", b, rd_valid_out, rd_element_out, e23[b]);
            else passed++;
            tick();
        end
        rd_ready_in = 1'b0;
    endtask

    task automatic test_hazard();
        for (int e = 0; e < 9; e++) wr(2'd2, e / 3, e % 3, 3, 3, 16'h2000 + 16'(e));
        rd_ready_in = 1'b1;
        rd_req_in = 1'b1; rd_addr_in = 2'd2;
        tick();
        rd_req_in = 1'b0;
        tick();
        checks++;
        if ({rd_valid_out, rd_element_out} !== {1'b1, 16'h2001}) $display("FAIL hazard_pre got v=%b e=%h exp v=1 e=2001", rd_valid_out, rd_element_out);
        else passed++;
        wr(2'd2, 0, 0, 3, 3, 16'hAAAA);
        checks++;
        if ({rd_valid_out, rd_busy_out, err_out, slot_valid_out[2]} !== 4'b0010) $display("FAIL hazard_abort got %b exp 0010", {rd_valid_out, rd_busy_out, err_out, slot_valid_out[2]});
        else passed++;
        tick();
        checks++;
        if (err_out !== 1'b0) $display("FAIL hazard_err_pulse got %b exp 0", err_out);
        else passed++;
        rd_ready_in = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        for (int e = 0; e < 9; e++) wr(2'd2, e / 3, e % 3, 3, 3, 16'h2000 + 16'(e));
        checks++;
        if (slot_valid_out[2] !== 1'b1) $display("FAIL rst_reload_valid got %b exp 1", slot_valid_out[2]);
        else passed++;
        rd_ready_in = 1'b1;
        rd_req_in = 1'b1; rd_addr_in = 2'd2;
        tick();
        rd_req_in = 1'b0;
        repeat (5) tick();
        checks++;
        if ({rd_valid_out, rd_element_out, rd_i_out, rd_j_out} !== {1'b1, 16'h2005, 3'd1, 3'd2}) $display("FAIL rst_beat5 got v=%b e=%h i=%0d j=%0d exp e=2005 i=1 j=2", rd_valid_out, rd_element_out, rd_i_out, rd_j_out);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_valid_out, rd_busy_out, rd_last_out, err_out, slot_valid_out, rd_element_out, rd_i_out, rd_j_out, rd_m_size_out, rd_n_size_out} !== '0)
            $display("FAIL rst_async got v=%b b=%b sv=%b e=%h i=%0d j=%0d m=%0d n=%0d exp all 0", rd_valid_out, rd_busy_out, slot_valid_out, rd_element_out, rd_i_out, rd_j_out, rd_m_size_out, rd_n_size_out);
        else passed++;
        tick();
        rst = 1'b0;
        rd_ready_in = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_invalid();
        test_stream_basic();
        test_same_cycle_req();
        test_backpressure();
        test_bad_write();
        test_hazard();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
